// File: rtl/ldpc_cnt_pkg.sv
// Shared types and default widths for the LDPC sweep counter.
package ldpc_cnt_pkg;

  localparam int unsigned LDPC_CNT_W   = 13;
  localparam int unsigned LDPC_LAYER_W = 4;
  localparam int unsigned LDPC_ITER_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Single counter stage that returns to 0 after last_val; wrap flags an incrementing wrap.
module wrap_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] val,
  output logic         wrap
);

  logic [W-1:0] val_q, val_d;

  always_comb begin
    wrap  = inc && (val_q == last_val);
    val_d = val_q;
    // clr wins so the terminating step leaves every stage at 0
    if (clr) begin
      val_d = '0;
    end else if (inc) begin
      val_d = wrap ? '0 : val_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/ldpc_sweep_counter.sv
// Three-level circulant/layer/iteration sweep counter with start/busy/done handshake.
// Optional early termination on convergence when LDPC_SWEEP_EARLY_STOP_EN is defined.
module ldpc_sweep_counter
  import ldpc_cnt_pkg::*;
#(
  parameter int unsigned CNT_W   = LDPC_CNT_W,
  parameter int unsigned LAYER_W = LDPC_LAYER_W,
  parameter int unsigned ITER_W  = LDPC_ITER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               enable,
  input  logic               early_stop,
  input  logic [CNT_W-1:0]   z_last,
  input  logic [LAYER_W-1:0] layer_last,
  input  logic [ITER_W-1:0]  iter_last,
  output logic [CNT_W-1:0]   count,
  output logic [LAYER_W-1:0] layer,
  output logic [ITER_W-1:0]  iter,
  output logic               last_in_layer,
  output logic               busy,
  output logic               done,
  output logic               stopped_early
);

  sweep_state_t state_q, state_d;

  logic [CNT_W-1:0]   z_last_q;
  logic [LAYER_W-1:0] layer_last_q;
  logic [ITER_W-1:0]  iter_last_q;
  logic               done_q;

  logic accept, step, finish, early_end;
  logic cnt_wrap, layer_wrap, iter_wrap;

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == RUN) && enable;

`ifdef LDPC_SWEEP_EARLY_STOP_EN
  // layer_wrap already implies an enabled step at the end of an iteration
  assign early_end = layer_wrap && early_stop;
`else
  logic unused_early_stop;
  assign unused_early_stop = early_stop;
  assign early_end = 1'b0;
`endif

  assign finish = iter_wrap || early_end;

  wrap_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (finish),
    .inc      (step),
    .last_val (z_last_q),
    .val      (count),
    .wrap     (cnt_wrap)
  );

  wrap_counter #(.W(LAYER_W)) u_layer (
    .clk      (clk),
    .reset    (reset),
    .clr      (finish),
    .inc      (cnt_wrap),
    .last_val (layer_last_q),
    .val      (layer),
    .wrap     (layer_wrap)
  );

  wrap_counter #(.W(ITER_W)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .clr      (finish),
    .inc      (layer_wrap),
    .last_val (iter_last_q),
    .val      (iter),
    .wrap     (iter_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      z_last_q     <= '0;
      layer_last_q <= '0;
      iter_last_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (accept) begin
        z_last_q     <= z_last;
        layer_last_q <= layer_last;
        iter_last_q  <= iter_last;
      end
    end
  end

`ifdef LDPC_SWEEP_EARLY_STOP_EN
  logic stopped_early_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stopped_early_q <= 1'b0;
    end else if (accept) begin
      stopped_early_q <= 1'b0;
    end else if (early_end) begin
      stopped_early_q <= 1'b1;
    end
  end

  assign stopped_early = stopped_early_q;
`else
  assign stopped_early = 1'b0;
`endif

  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign last_in_layer = busy && (count == z_last_q);

endmodule
